// File: rtl/complex_counter_checker_if.sv
// Consumer-side bundle between a multi-mode 4-bit counter and its sequence checker.
// The master drives the sampled counter stream; the slave (checker) returns its verdicts.
interface complex_counter_checker_if #(
   parameter int unsigned ERR_W = 8
) ();
   logic             Enable;
   logic [3:0]       Mode;
   logic [3:0]       Count;
   logic             Clear;
   logic [3:0]       Expected;
   logic             Mismatch;
   logic             Locked;
   logic             Fault;
   logic             ModeValid;
   logic [ERR_W-1:0] ErrCount;

   modport master (
      output Enable, Mode, Count, Clear,
      input  Expected, Mismatch, Locked, Fault, ModeValid, ErrCount
   );

   modport slave (
      input  Enable, Mode, Count, Clear,
      output Expected, Mismatch, Locked, Fault, ModeValid, ErrCount
   );
endinterface

// File: rtl/complex_counter_checker.sv
// Checks that a sampled 4-bit counter stream follows the sequence selected by Mode.
// Build option COMPLEX_COUNTER_CHECKER_RESYNC_EN re-seeds the prediction from Count on a mismatch.
module complex_counter_checker #(
   parameter int unsigned ERR_W       = 8,
   parameter int unsigned FAULT_LIMIT = 3
) (
   input logic                      Clk,
   input logic                      Reset,
   complex_counter_checker_if.slave bus
);

   typedef enum logic [1:0] {StIdle, StAcquire, StTrack, StFault} state_e;

   localparam logic [3:0] LimitW = 4'(FAULT_LIMIT);

   state_e           state_q, state_d;
   logic [3:0]       expected_q, expected_d;
   logic [3:0]       mode_q, mode_d;
   logic [3:0]       consec_q, consec_d;
   logic [ERR_W-1:0] err_q, err_d;
   logic             mismatch_q, mismatch_d;
   logic             locked_q, locked_d;
   logic             mode_valid_q, mode_valid_d;

   logic             acquire;
   logic             legal;
   logic [3:0]       nxt_count;

   function automatic logic [3:0] gray_next(input logic [3:0] g);
      logic [3:0] b;
      b[3] = g[3];
      b[2] = b[3] ^ g[2];
      b[1] = b[2] ^ g[1];
      b[0] = b[1] ^ g[0];
      b = b + 4'd1;
      return b ^ (b >> 1);
   endfunction

   function automatic logic [3:0] nxt(input logic [2:0] m, input logic [3:0] x);
      logic [3:0] r;
      case (m)
         3'd0:    r = x + 4'd1;
         3'd1:    r = x - 4'd1;
         3'd2:    r = (x == 4'd9) ? 4'd0 : x + 4'd1;
         3'd3:    r = (x == 4'd0) ? 4'd9 : x - 4'd1;
         3'd4:    r = gray_next(x);
         3'd5:    r = {x[2:0], ~x[3]};
         default: r = x + 4'd2;  // even/odd up wrap naturally mod 16
      endcase
      return r;
   endfunction

   function automatic logic is_legal(input logic [2:0] m, input logic [3:0] x);
      logic r;
      case (m)
         3'd2, 3'd3: r = (x <= 4'd9);
         3'd5:       r = (x inside {4'd0, 4'd1, 4'd3, 4'd7, 4'd15, 4'd14, 4'd12, 4'd8});
         3'd6:       r = ~x[0];
         3'd7:       r = x[0];
         default:    r = 1'b1;
      endcase
      return r;
   endfunction

   assign legal     = is_legal(bus.Mode[2:0], bus.Count);
   assign nxt_count = nxt(bus.Mode[2:0], bus.Count);
   // A changed Mode restarts acquisition even while tracking.
   assign acquire   = (state_q != StTrack) || (bus.Mode != mode_q);

   always_comb begin
      state_d      = state_q;
      expected_d   = expected_q;
      mode_d       = mode_q;
      consec_d     = consec_q;
      err_d        = err_q;
      mismatch_d   = 1'b0;
      locked_d     = locked_q;
      mode_valid_d = mode_valid_q;

      if (bus.Clear) begin
         state_d    = StIdle;
         expected_d = 4'd0;
         mode_d     = 4'd0;
         consec_d   = 4'd0;
         err_d      = '0;
         locked_d   = 1'b0;
      end else if (bus.Enable) begin
         mode_d       = bus.Mode;
         mode_valid_d = ~bus.Mode[3];
         if (state_q == StFault) begin
            locked_d = 1'b0;
         end else if (bus.Mode[3]) begin
            state_d  = StIdle;
            locked_d = 1'b0;
            consec_d = 4'd0;
         end else if (acquire) begin
            consec_d = 4'd0;
            if (legal) begin
               expected_d = nxt_count;
               state_d    = StTrack;
               locked_d   = 1'b1;
            end else begin
               mismatch_d = 1'b1;
               state_d    = StAcquire;
               locked_d   = 1'b0;
            end
         end else if (bus.Count == expected_q) begin
            expected_d = nxt_count;
            consec_d   = 4'd0;
            locked_d   = 1'b1;
         end else begin
            mismatch_d = 1'b1;
            locked_d   = 1'b0;
            consec_d   = consec_q + 4'd1;
`ifdef COMPLEX_COUNTER_CHECKER_RESYNC_EN
            if (legal) begin
               expected_d = nxt_count;
            end else begin
               state_d = StAcquire;
            end
`else
            expected_d = nxt(bus.Mode[2:0], expected_q);
`endif
            if (consec_d >= LimitW) begin
               state_d = StFault;
            end
         end
         if (mismatch_d && (err_q != {ERR_W{1'b1}})) begin
            err_d = err_q + 1'b1;
         end
      end
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q      <= StIdle;
         expected_q   <= 4'd0;
         mode_q       <= 4'd0;
         consec_q     <= 4'd0;
         err_q        <= '0;
         mismatch_q   <= 1'b0;
         locked_q     <= 1'b0;
         mode_valid_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         expected_q   <= expected_d;
         mode_q       <= mode_d;
         consec_q     <= consec_d;
         err_q        <= err_d;
         mismatch_q   <= mismatch_d;
         locked_q     <= locked_d;
         mode_valid_q <= mode_valid_d;
      end
   end

   assign bus.Expected  = expected_q;
   assign bus.Mismatch  = mismatch_q;
   assign bus.Locked    = locked_q;
   assign bus.Fault     = (state_q == StFault);
   assign bus.ModeValid = mode_valid_q;
   assign bus.ErrCount  = err_q;

endmodule

// File: tb/tb_complex_counter_checker.sv
// Bench for complex_counter_checker: directed vector table, hand sequences, then random
// stimulus checked against a sequence-table reference model.
module tb_complex_counter_checker;

   localparam int ERR_W   = 8;
   localparam int LIMIT   = 3;
   localparam int ERR_MAX = (1 << ERR_W) - 1;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   errors = 0;
   int   checks = 0;

   always #5 clk = ~clk;

   complex_counter_checker_if #(.ERR_W(ERR_W)) bus ();

   complex_counter_checker #(
      .ERR_W      (ERR_W),
      .FAULT_LIMIT(LIMIT)
   ) dut (
      .Clk  (clk),
      .Reset(rst),
      .bus  (bus)
   );

   // Each supported mode is described by its legal values listed in stepping order.
   int seq[8][16];
   int slen[8];

   function automatic void build_seqs();
      int johnson[8] = '{0, 1, 3, 7, 15, 14, 12, 8};
      for (int i = 0; i < 16; i++) begin
         seq[0][i] = i;
         seq[1][i] = 15 - i;
         seq[4][i] = i ^ (i >> 1);
      end
      for (int i = 0; i < 10; i++) begin
         seq[2][i] = i;
         seq[3][i] = 9 - i;
      end
      for (int i = 0; i < 8; i++) begin
         seq[5][i] = johnson[i];
         seq[6][i] = 2 * i;
         seq[7][i] = 2 * i + 1;
      end
      slen = '{16, 16, 10, 10, 16, 8, 8, 8};
   endfunction

   function automatic int idx_of(int m, int x);
      for (int i = 0; i < slen[m]; i++) if (seq[m][i] == x) return i;
      return -1;
   endfunction

   function automatic int mnext(int m, int x);
      return seq[m][(idx_of(m, x) + 1) % slen[m]];
   endfunction

   // Reference model: phase 0 idle, 1 acquire, 2 track, 3 fault.
   int m_phase, m_exp, m_modeq, m_consec, m_err;
   bit m_mis, m_lock, m_mv;

   task automatic model_step(bit r, bit en, bit clr, int mode, int cnt);
      bit changed;
      int i;
      m_mis = 0;
      if (r || clr) begin
         m_phase = 0; m_exp = 0; m_modeq = 0; m_consec = 0; m_err = 0; m_lock = 0;
         if (r) m_mv = 0;
      end else if (en) begin
         changed = (mode != m_modeq);
         m_modeq = mode;
         m_mv    = (mode < 8);
         if (m_phase == 3) begin
            m_lock = 0;
         end else if (mode >= 8) begin
            m_phase = 0; m_lock = 0; m_consec = 0;
         end else begin
            i = idx_of(mode, cnt);
            if (m_phase != 2 || changed) begin
               m_consec = 0;
               if (i >= 0) begin
                  m_exp = mnext(mode, cnt); m_phase = 2; m_lock = 1;
               end else begin
                  m_mis = 1; m_phase = 1; m_lock = 0;
               end
            end else if (cnt == m_exp) begin
               m_exp = mnext(mode, cnt); m_consec = 0; m_lock = 1;
            end else begin
               m_mis = 1; m_lock = 0; m_consec++;
`ifdef COMPLEX_COUNTER_CHECKER_RESYNC_EN
               if (i >= 0) m_exp = mnext(mode, cnt);
               else m_phase = 1;
`else
               m_exp = mnext(mode, m_exp);
`endif
               if (m_consec >= LIMIT) m_phase = 3;
            end
            if (m_mis && m_err < ERR_MAX) m_err++;
         end
      end
   endtask

   task automatic chk(string name, int act, int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic check_outs(string tag, int e_exp, int e_mis, int e_lock, int e_flt,
                             int e_mv, int e_err);
      chk({tag, ".Expected"}, int'(bus.Expected), e_exp);
      chk({tag, ".Mismatch"}, int'(bus.Mismatch), e_mis);
      chk({tag, ".Locked"}, int'(bus.Locked), e_lock);
      chk({tag, ".Fault"}, int'(bus.Fault), e_flt);
      chk({tag, ".ModeValid"}, int'(bus.ModeValid), e_mv);
      chk({tag, ".ErrCount"}, int'(bus.ErrCount), e_err);
   endtask

   task automatic step(bit r, bit en, bit clr, int mode, int cnt);
      rst        = r;
      bus.Enable = en;
      bus.Clear  = clr;
      bus.Mode   = 4'(mode);
      bus.Count  = 4'(cnt);
      @(posedge clk);
      #1;
      model_step(r, en, clr, mode, cnt);
   endtask

   typedef struct {
      bit r, en, clr;
      int mode, cnt;
      int e_exp, e_mis, e_lock, e_flt, e_mv, e_err;
   } vec_t;

   vec_t tbl[26];

   initial begin
      int e21;
      int mode, cnt;
      build_seqs();
      bus.Enable = 0; bus.Clear = 0; bus.Mode = 0; bus.Count = 0;
`ifdef COMPLEX_COUNTER_CHECKER_RESYNC_EN
      e21 = 1;
`else
      e21 = 3;
`endif
      tbl = '{
         '{1, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0},
         '{0, 1, 0, 2, 7,   8, 0, 1, 0, 1, 0},
         '{0, 1, 0, 2, 8,   9, 0, 1, 0, 1, 0},
         '{0, 1, 0, 2, 9,   0, 0, 1, 0, 1, 0},
         '{0, 1, 0, 2, 0,   1, 0, 1, 0, 1, 0},
         '{0, 1, 0, 2, 1,   2, 0, 1, 0, 1, 0},
         '{1, 1, 0, 2, 1,   0, 0, 0, 0, 0, 0},
         '{0, 1, 0, 2, 12,  0, 1, 0, 0, 1, 1},
         '{0, 1, 0, 2, 12,  0, 1, 0, 0, 1, 2},
         '{0, 1, 0, 2, 3,   4, 0, 1, 0, 1, 2},
         '{1, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0},
         '{0, 1, 0, 5, 0,   1, 0, 1, 0, 1, 0},
         '{0, 1, 0, 5, 1,   3, 0, 1, 0, 1, 0},
         '{0, 1, 0, 5, 3,   7, 0, 1, 0, 1, 0},
         '{0, 1, 0, 5, 7,  15, 0, 1, 0, 1, 0},
         '{0, 1, 0, 5, 15, 14, 0, 1, 0, 1, 0},
         '{0, 1, 0, 5, 14, 12, 0, 1, 0, 1, 0},
         '{0, 1, 0, 5, 12,  8, 0, 1, 0, 1, 0},
         '{0, 1, 0, 5, 8,   0, 0, 1, 0, 1, 0},
         '{0, 1, 0, 5, 0,   1, 0, 1, 0, 1, 0},
         '{0, 1, 0, 5, 5, e21, 1, 0, 0, 1, 1},
         '{0, 0, 0, 5, 9, e21, 0, 0, 0, 1, 1},
         '{0, 0, 0, 5, 9, e21, 0, 0, 0, 1, 1},
         '{0, 1, 0, 9, 3, e21, 0, 0, 0, 0, 1},
         '{0, 1, 0, 0, 4,   5, 0, 1, 0, 1, 1},
         '{0, 1, 1, 0, 5,   0, 0, 0, 0, 1, 0}
      };
      @(negedge clk);

      foreach (tbl[i]) begin
         step(tbl[i].r, tbl[i].en, tbl[i].clr, tbl[i].mode, tbl[i].cnt);
         check_outs($sformatf("row%0d", i), tbl[i].e_exp, tbl[i].e_mis, tbl[i].e_lock,
                    tbl[i].e_flt, tbl[i].e_mv, tbl[i].e_err);
      end

      // Binary up across the 15->0 wrap.
      step(1, 0, 0, 0, 0);
      for (int c = 0; c <= 16; c++) begin
         step(0, 1, 0, 0, c % 16);
         check_outs($sformatf("binup%0d", c), (c + 1) % 16, 0, 1, 0, 1, 0);
      end

      // Skipped value 4->6 then 7,8.
      step(1, 0, 0, 0, 0);
      for (int c = 0; c <= 4; c++) step(0, 1, 0, 0, c);
      step(0, 1, 0, 0, 6);
      check_outs("skip6", e21 == 1 ? 7 : 6, 1, 0, 0, 1, 1);
      step(0, 1, 0, 0, 7);
`ifdef COMPLEX_COUNTER_CHECKER_RESYNC_EN
      check_outs("skip7", 8, 0, 1, 0, 1, 1);
      step(0, 1, 0, 0, 8);
      check_outs("skip8", 9, 0, 1, 0, 1, 1);
`else
      check_outs("skip7", 7, 1, 0, 0, 1, 2);
      step(0, 1, 0, 0, 8);
      check_outs("skip8", 8, 1, 0, 1, 1, 3);
      step(0, 1, 0, 0, 9);
      check_outs("fault_hold", 8, 0, 0, 1, 1, 3);
`endif

      // Force FAULT with a stuck counter, then unsupported Mode, Enable toggling and Clear.
      step(1, 0, 0, 0, 0);
      step(0, 1, 0, 0, 0);
      step(0, 1, 0, 0, 5);
      step(0, 1, 0, 0, 5);
      step(0, 1, 0, 0, 5);
      chk("stuck.Fault", int'(bus.Fault), 1);
      chk("stuck.ErrCount", int'(bus.ErrCount), 3);
      step(0, 1, 0, 9, 0);
      chk("m9.Fault", int'(bus.Fault), 1);
      chk("m9.ModeValid", int'(bus.ModeValid), 0);
      chk("m9.Mismatch", int'(bus.Mismatch), 0);
      step(0, 0, 0, 9, 1);
      step(0, 1, 0, 9, 2);
      chk("m9b.Fault", int'(bus.Fault), 1);
      chk("m9b.ErrCount", int'(bus.ErrCount), 3);
      step(0, 1, 1, 0, 3);
      check_outs("clear", 0, 0, 0, 0, 0, 0);
      step(0, 1, 0, 0, 3);
      check_outs("reacq", 4, 0, 1, 0, 1, 0);

      // Reset beats a mismatching sample; Enable=0 then holds.
      step(1, 0, 0, 0, 0);
      step(0, 1, 0, 1, 7);
      step(0, 1, 0, 1, 6);
      step(0, 1, 0, 1, 5);
      check_outs("down5", 4, 0, 1, 0, 1, 0);
      step(1, 1, 0, 1, 9);
      check_outs("rst_mis", 0, 0, 0, 0, 0, 0);
      for (int k = 0; k < 4; k++) step(0, 0, 0, 1, 9);
      check_outs("rst_hold", 0, 0, 0, 0, 0, 0);

      // ErrCount saturation while Mismatch keeps pulsing.
      for (int k = 0; k < ERR_MAX + 5; k++) step(0, 1, 0, 2, 12);
      chk("sat.ErrCount", int'(bus.ErrCount), ERR_MAX);
      chk("sat.Mismatch", int'(bus.Mismatch), 1);

      // Random stimulus against the reference model.
      step(1, 0, 0, 0, 0);
      mode = 0;
      for (int n = 0; n < 3000; n++) begin
         bit r, en, clr;
         r   = ($urandom_range(199) == 0);
         clr = ($urandom_range(99) == 0);
         en  = ($urandom_range(99) < 85);
         if ($urandom_range(15) == 0) mode = ($urandom_range(3) == 0) ?
                                            $urandom_range(15) : $urandom_range(7);
         if (m_phase == 2 && $urandom_range(9) < 7) cnt = m_exp;
         else if (mode < 8 && $urandom_range(1) == 0) cnt = seq[mode][$urandom_range(slen[mode] - 1)];
         else cnt = $urandom_range(15);
         step(r, en, clr, mode, cnt);
         check_outs($sformatf("rnd%0d", n), m_exp, int'(m_mis), int'(m_lock),
                    int'(m_phase == 3), int'(m_mv), m_err);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
